// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out transmitter.
// Defining PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {StIdle, StShift} state_e;

`ifdef PISO_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    function automatic int unsigned frame_len(input int unsigned width);
        return width + PARITY_BITS;
    endfunction

    // Wide enough for the bit index of a frame including the optional parity bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of piso_serializer.
// master = word source / observer, slave = the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output din, load_valid,
        input  load_ready, sout, sout_valid, frame_start, busy, done
    );

    modport slave (
        input  din, load_valid,
        output load_ready, sout, sout_valid, frame_start, busy, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Loadable shift register that presents its next outgoing bit from a flop.
// Zeros shift in behind the data, so the output drops to 0 once a frame is exhausted.
module piso_shift_reg #(
    parameter int unsigned LEN       = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           shift,
    input  logic [LEN-1:0] data,
    output logic           out_bit
);
    logic [LEN-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= data;
        end else if (shift) begin
            if (MSB_FIRST) shift_q <= {shift_q[LEN-2:0], 1'b0};
            else           shift_q <= {1'b0, shift_q[LEN-1:1]};
        end
    end

    assign out_bit = MSB_FIRST ? shift_q[LEN-1] : shift_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and framing strobes.
// Optional even-parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);
    localparam int unsigned    FRAME_LEN = frame_len(WIDTH);
    localparam int unsigned    CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX  = CW'(FRAME_LEN - 1);

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   valid_q;
    logic                   start_q;
    logic                   done_q;
    logic                   ready;
    logic                   accept;
    logic                   shift;
    logic                   sout_bit;
    logic [FRAME_LEN-1:0]   frame_word;

`ifdef PISO_PARITY_EN
    // Parity sits at the end of the shift order so it leaves after the last data bit.
    assign frame_word = MSB_FIRST ? {bus.din, ^bus.din} : {^bus.din, bus.din};
`else
    assign frame_word = bus.din;
`endif

    // The last-bit cycle also accepts, which is what makes frames back-to-back.
    assign ready  = (state_q == StIdle) || done_q;
    assign accept = bus.load_valid && ready;
    assign shift  = (state_q == StShift) && !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (accept) begin
            state_q <= StShift;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            start_q <= 1'b1;
            done_q  <= 1'b0;
        end else if (state_q == StShift) begin
            start_q <= 1'b0;
            if (done_q) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_q + CW'(1);
                done_q  <= (cnt_q + CW'(1)) == LAST_IDX;
            end
        end else begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end
    end

    piso_shift_reg #(
        .LEN       (FRAME_LEN),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (shift),
        .data    (frame_word),
        .out_bit (sout_bit)
    );

    assign bus.load_ready  = ready;
    assign bus.sout        = sout_bit;
    assign bus.sout_valid  = valid_q;
    assign bus.busy        = valid_q;
    assign bus.frame_start = start_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances driven in lockstep,
// expected serial bits queued with their due cycle and checked as they appear.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    typedef struct {
        logic [3:0] din;
        logic [0:3] msb_seq;  // transmission order, left bit first
        logic [0:3] lsb_seq;
        logic       par;
    } vec_t;

    typedef struct {
        int   cyc;
        logic b;
        logic fs;
        logic dn;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl[9];
    rec_t q_msb[$];
    rec_t q_lsb[$];

    piso_serializer_if #(.WIDTH(4)) bus_msb ();
    piso_serializer_if #(.WIDTH(4)) bus_lsb ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_msb));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_lsb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d);
        bus_msb.load_valid = v;
        bus_lsb.load_valid = v;
        bus_msb.din        = d;
        bus_lsb.din        = d;
    endtask

    task automatic chk_ready(input string name, input logic exp);
        chk({"msb_", name}, int'(bus_msb.load_ready), int'(exp));
        chk({"lsb_", name}, int'(bus_lsb.load_ready), int'(exp));
    endtask

    // Queue the first n bits of vector vi, first bit due at cycle start.
    task automatic push_frame(input int vi, input int start, input int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r.cyc = start + k;
            r.fs  = (k == 0);
            r.dn  = (k == FL - 1);
            r.b   = (k < 4) ? tbl[vi].msb_seq[k] : tbl[vi].par;
            q_msb.push_back(r);
            r.b   = (k < 4) ? tbl[vi].lsb_seq[k] : tbl[vi].par;
            q_lsb.push_back(r);
        end
    endtask

    // Present vector vi in the current cycle, expect it accepted, return one cycle later.
    task automatic load_word(input int vi, input int n);
        drive(1'b1, tbl[vi].din);
        chk_ready("ready_at_load", 1'b1);
        push_frame(vi, cyc + 1, n);
        step();
        drive(1'b0, 4'h0);
    endtask

    task automatic mon(input bit is_msb, input logic so, input logic sv, input logic fs,
                       input logic bz, input logic dn);
        rec_t  r;
        int    n;
        string t;
        t = is_msb ? "msb" : "lsb";
        n = is_msb ? q_msb.size() : q_lsb.size();
        chk({t, "_busy"}, int'(bz), int'(sv));
        if (sv) begin
            if (n == 0) begin
                chk({t, "_unexpected_bit"}, 1, 0);
            end else begin
                r = is_msb ? q_msb.pop_front() : q_lsb.pop_front();
                chk({t, "_bit_cycle"}, cyc, r.cyc);
                chk({t, "_sout"}, int'(so), int'(r.b));
                chk({t, "_frame_start"}, int'(fs), int'(r.fs));
                chk({t, "_done"}, int'(dn), int'(r.dn));
            end
        end else begin
            chk({t, "_idle_outputs"}, int'({so, fs, dn}), 0);
            if (n > 0) begin
                r = is_msb ? q_msb[0] : q_lsb[0];
                if (r.cyc <= cyc) begin
                    chk({t, "_missing_bit_cycle"}, cyc, r.cyc - 1);
                    if (is_msb) void'(q_msb.pop_front());
                    else        void'(q_lsb.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b1, bus_msb.sout, bus_msb.sout_valid, bus_msb.frame_start, bus_msb.busy,
            bus_msb.done);
        mon(1'b0, bus_lsb.sout, bus_lsb.sout_valid, bus_lsb.frame_start, bus_lsb.busy,
            bus_lsb.done);
    end

    initial begin
        tbl[0] = '{4'b1011, 4'b1011, 4'b1101, 1'b1};
        tbl[1] = '{4'b1001, 4'b1001, 4'b1001, 1'b0};
        tbl[2] = '{4'hA,    4'b1010, 4'b0101, 1'b0};
        tbl[3] = '{4'h5,    4'b0101, 4'b1010, 1'b0};
        tbl[4] = '{4'h8,    4'b1000, 4'b0001, 1'b1};
        tbl[5] = '{4'h0,    4'b0000, 4'b0000, 1'b0};
        tbl[6] = '{4'hF,    4'b1111, 4'b1111, 1'b0};
        tbl[7] = '{4'h6,    4'b0110, 4'b0110, 1'b0};
        tbl[8] = '{4'h3,    4'b0011, 4'b1100, 1'b0};

        rst = 1'b1;
        drive(1'b0, 4'h0);
        repeat (3) step();
        chk_ready("ready_in_reset", 1'b1);
        rst = 1'b0;
        step();
        chk_ready("ready_after_reset", 1'b1);

        // Single frames from the table; ready drops mid-frame, returns on done.
        for (int i = 0; i < 6; i++) begin
            load_word(i, FL);
            chk_ready("ready_mid_frame", 1'b0);
            repeat (FL - 1) step();
            chk_ready("ready_on_done", 1'b1);
            step();
            chk_ready("ready_idle", 1'b1);
            step();
        end

        // Back-to-back: valid held high, second word accepted on the done cycle.
        drive(1'b1, 4'hA);
        chk_ready("b2b_first_ready", 1'b1);
        push_frame(2, cyc + 1, FL);
        step();
        drive(1'b1, 4'h5);
        for (int k = 1; k < FL; k++) begin
            chk_ready("b2b_wait_ready", 1'b0);
            step();
        end
        chk_ready("b2b_second_ready", 1'b1);
        push_frame(3, cyc + 1, FL);
        step();
        drive(1'b0, 4'h0);
        repeat (FL + 1) step();

        // Mid-frame reset: only the first two bits ever appear, no done.
        load_word(6, 2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_ready("ready_after_abort", 1'b1);
        repeat (2) step();

        // Load attempt while busy is ignored; frame carries the original word.
        load_word(7, FL);
        step();
        drive(1'b1, 4'h3);
        chk_ready("ready_while_busy", 1'b0);
        step();
        drive(1'b0, 4'h0);
        repeat (FL + 2) step();

        chk("msb_queue_drained", q_msb.size(), 0);
        chk("lsb_queue_drained", q_lsb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
